// File: rtl/alu_pipe.sv
// Registered, handshaked ALU with flags, saturating add/sub and a
// multi-cycle signed shift-add multiplier.
module alu_pipe #(
    parameter int WIDTH = 16,
    parameter bit SAT   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             ovfl,
    output logic             zero,
    output logic             neg
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_SLL = 4'h5;
    localparam logic [3:0] OP_SRA = 4'h6;
    localparam logic [3:0] OP_ROR = 4'h7;
    localparam logic [3:0] OP_MUL = 4'h8;

    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [SHW-1:0]   CNT_LAST = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    state_t state, state_n;

    logic               rdy_en;
    logic               accept;
    logic               is_mul;
    logic               last;
    logic [SHW-1:0]     cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_n;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   dif;
    logic [WIDTH-1:0]   res;
    logic               res_ovf;
    logic               msign;
    logic               mul_ovf;

    assign accept = in_valid & in_ready;
    assign is_mul = (ctrl == OP_MUL);
    assign last   = (cnt == CNT_LAST);

    // rdy_en keeps in_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rdy_en <= 1'b0;
        end else begin
            state  <= state_n;
            rdy_en <= 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (accept) state_n = is_mul ? MUL : DONE;
            end
            MUL: begin
                if (last) state_n = DONE;
            end
            DONE: begin
                if (accept)         state_n = is_mul ? MUL : DONE;
                else if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: in_ready = rdy_en;
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: ;
        endcase
    end

    always_comb begin
        sum     = a + b;
        dif     = a - b;
        res     = '0;
        res_ovf = 1'b0;
        unique case (ctrl)
            OP_ADD: begin
                res     = sum;
                res_ovf = (a[WIDTH-1] == b[WIDTH-1]) &&
                          (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res     = dif;
                res_ovf = (a[WIDTH-1] != b[WIDTH-1]) &&
                          (dif[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_SLL: res = a << b[SHW-1:0];
            OP_SRA: res = $unsigned($signed(a) >>> b[SHW-1:0]);
            OP_ROR: res = WIDTH'({a, a} >> b[SHW-1:0]);
            default: ;
        endcase
        // overflow direction follows the sign of a for both add and sub
        if (SAT && res_ovf) res = a[WIDTH-1] ? SMIN : SMAX;
    end

    // sign-magnitude multiply: unsigned shift-add, sign applied at the end
    assign abs_a   = a[WIDTH-1] ? -a : a;
    assign abs_b   = b[WIDTH-1] ? -b : b;
    assign acc_n   = acc + (mplier[0] ? mcand : '0);
    assign prod    = msign ? -acc_n : acc_n;
    assign mul_ovf = !((prod[2*WIDTH-1:WIDTH-1] == '0) ||
                       (prod[2*WIDTH-1:WIDTH-1] == '1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            msign  <= 1'b0;
            cnt    <= '0;
            out    <= '0;
            ovfl   <= 1'b0;
            zero   <= 1'b0;
            neg    <= 1'b0;
        end else if (accept) begin
            if (is_mul) begin
                acc    <= '0;
                mcand  <= {{WIDTH{1'b0}}, abs_a};
                mplier <= abs_b;
                msign  <= a[WIDTH-1] ^ b[WIDTH-1];
                cnt    <= '0;
            end else begin
                out  <= res;
                ovfl <= res_ovf;
                zero <= (res == '0);
                neg  <= res[WIDTH-1];
            end
        end else if (state == MUL) begin
            acc    <= acc_n;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + SHW'(1);
            if (last) begin
                out  <= prod[WIDTH-1:0];
                ovfl <= mul_ovf;
                zero <= (prod[WIDTH-1:0] == '0);
                neg  <= prod[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed scoreboard bench for alu_pipe (WIDTH=16), saturating and
// wrapping instances driven in lockstep.
module tb_alu_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;
    logic        ovfl;
    logic        zero;
    logic        neg;

    logic        w_in_ready;
    logic        w_valid;
    logic [15:0] w_out;
    logic        w_ovfl;
    logic        w_zero;
    logic        w_neg;

    int ncmp  = 0;
    int nfail = 0;

    typedef struct packed {
        logic [15:0] out;
        logic        ovfl;
        logic        zero;
        logic        neg;
    } exp_t;

    exp_t sbq[$];

    alu_pipe #(.WIDTH(16), .SAT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ctrl(ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .ovfl(ovfl), .zero(zero), .neg(neg)
    );

    alu_pipe #(.WIDTH(16), .SAT(1'b0)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(w_in_ready),
        .a(a), .b(b), .ctrl(ctrl),
        .out_valid(w_valid), .out_ready(out_ready),
        .out(w_out), .ovfl(w_ovfl), .zero(w_zero), .neg(w_neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                chk("spurious_out", out_valid, 1'b0);
            end else begin
                e = sbq.pop_front();
                chk("out", out, e.out);
                chk("ovfl", ovfl, e.ovfl);
                chk("zero", zero, e.zero);
                chk("neg", neg, e.neg);
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [15:0] xa,
                         input logic [15:0] xb, input logic [15:0] eo,
                         input logic eov);
        exp_t e;
        logic ok;
        e.out  = eo;
        e.ovfl = eov;
        e.zero = (eo == 16'h0000);
        e.neg  = eo[15];
        sbq.push_back(e);
        ctrl     = op;
        a        = xa;
        b        = xb;
        in_valid = 1'b1;
        ok       = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
        end
        chk("accept", ok, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        ctrl     = 4'($urandom);
    endtask

    task automatic wait_valid(output int n, output int irbad);
        n     = 1;
        irbad = 0;
        while (!out_valid && n < 100) begin
            if (in_ready) irbad++;
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run(input string tag, input logic [3:0] op,
                       input logic [15:0] xa, input logic [15:0] xb,
                       input logic [15:0] eo, input logic eov,
                       input int elat);
        int n;
        int irb;
        issue(op, xa, xb, eo, eov);
        wait_valid(n, irb);
        chk({tag, "_lat"}, n, elat);
        if (elat > 1) chk({tag, "_inrdy"}, irb, 0);
    endtask

    initial begin
        logic [15:0] hold;
        logic [2:0]  hflg;
        int          seen;

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        ctrl      = '0;
        #1 rst_n  = 1'b0;
        #2;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out", out, 16'h0000);
        chk("rst_flags", {ovfl, zero, neg}, 3'b000);
        #19 rst_n = 1'b1;
        #1;
        chk("rel_in_ready_low", in_ready, 1'b0);
        @(posedge clk);
        #1;
        chk("rel_in_ready_high", in_ready, 1'b1);

        run("add_sat", 4'h0, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b1, 1);
        chk("add_wrap_out", w_out, 16'h8000);
        chk("add_wrap_ovfl", w_ovfl, 1'b1);
        chk("add_wrap_neg", w_neg, 1'b1);
        chk("add_wrap_valid", w_valid, 1'b1);

        run("sub_sat", 4'h1, 16'h8000, 16'h0001, 16'h8000, 1'b1, 1);
        run("sub_zero", 4'h1, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1);
        run("ror", 4'h7, 16'h8001, 16'h0004, 16'h1800, 1'b0, 1);
        run("sra", 4'h6, 16'h8000, 16'h0014, 16'hF800, 1'b0, 1);
        run("sll", 4'h5, 16'h0001, 16'h000F, 16'h8000, 1'b0, 1);
        run("sll_0", 4'h5, 16'h1234, 16'h0010, 16'h1234, 1'b0, 1);
        run("ror_0", 4'h7, 16'hA5C3, 16'hFFF0, 16'hA5C3, 1'b0, 1);
        run("and", 4'h2, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1);
        run("or", 4'h3, 16'hF000, 16'h000F, 16'hF00F, 1'b0, 1);
        run("rsvd", 4'hF, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1);

        run("mul_neg", 4'h8, 16'h0003, 16'hFFFB, 16'hFFF1, 1'b0, 17);
        run("mul_ovf", 4'h8, 16'h0100, 16'h0100, 16'h0000, 1'b1, 17);

        @(posedge clk);
        #1;
        out_ready = 1'b0;
        run("bp_add", 4'h0, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1);
        hold = out;
        hflg = {ovfl, zero, neg};
        begin
            exp_t e;
            e.out  = 16'h0FF0;
            e.ovfl = 1'b0;
            e.zero = 1'b0;
            e.neg  = 1'b0;
            sbq.push_back(e);
        end
        ctrl     = 4'h4;
        a        = 16'h00FF;
        b        = 16'h0F0F;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_out_hold", out, hold);
            chk("bp_flag_hold", {ovfl, zero, neg}, hflg);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_valid", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("xor_out", out, 16'h0FF0);
        chk("xor_valid", out_valid, 1'b1);

        issue(4'h8, 16'h0007, 16'h0007, 16'h0031, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sbq.delete();
        #1;
        chk("mrst_valid", out_valid, 1'b0);
        chk("mrst_out", out, 16'h0000);
        chk("mrst_in_ready", in_ready, 1'b0);
        chk("mrst_flags", {ovfl, zero, neg}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_rel_ready", in_ready, 1'b1);
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("mrst_no_result", seen, 0);

        run("add_post", 4'h0, 16'h0002, 16'h0003, 16'h0005, 1'b0, 1);

        for (int i = 0; i < 20 && sbq.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

endmodule
